free_list: RTL

//  Physical-register free list for the 2-wide rename stage. It is the supply/return end of the reorder buffer's

---
 rtl/free_list_if.sv | 33 +++
 rtl/free_list.sv | 80 ++++++++
 2 files changed

// File: rtl/free_list_if.sv
// Rename-side alloc and commit-side release bundle of the physical-register free list.
interface free_list_if #(
    parameter int PW = 6
);
    logic          alloc0_req_i;
    logic          alloc1_req_i;
    logic [PW-1:0] alloc0_preg_o;
    logic [PW-1:0] alloc1_preg_o;
    logic          alloc_grant_o;
    logic          release0_en_i;
    logic [PW-1:0] release0_preg_i;
    logic          release1_en_i;
    logic [PW-1:0] release1_preg_i;
    logic [PW:0]   free_count_o;
    logic          empty_o;
    logic          overflow_err_o;

    modport slave (
        input  alloc0_req_i, alloc1_req_i,
        input  release0_en_i, release0_preg_i,
        input  release1_en_i, release1_preg_i,
        output alloc0_preg_o, alloc1_preg_o, alloc_grant_o,
        output free_count_o, empty_o, overflow_err_o
    );

    modport master (
        output alloc0_req_i, alloc1_req_i,
        output release0_en_i, release0_preg_i,
        output release1_en_i, release1_preg_i,
        input  alloc0_preg_o, alloc1_preg_o, alloc_grant_o,
        input  free_count_o, empty_o, overflow_err_o
    );
endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of preg indices feeding 2-wide rename,
// refilled by old_dest releases from ROB commit.
module free_list #(
    parameter int NUM_P_REGS = 64,
    parameter int NUM_A_REGS = 32,
    localparam int PW = $clog2(NUM_P_REGS)
) (
    input logic        clk_i,
    input logic        rst_ni,
    free_list_if.slave fl
);
    localparam logic [PW:0] MAX_CNT = (PW+1)'(NUM_P_REGS - 1);
    localparam logic [PW:0] RST_CNT = (PW+1)'(NUM_P_REGS - NUM_A_REGS);

    logic [PW-1:0] fifo_q [NUM_P_REGS];
    logic [PW-1:0] fifo_d [NUM_P_REGS];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;

    logic [1:0]  n_req;
    logic [1:0]  n_grant;
    logic        grant;
    logic [PW:0] base;
    logic [PW:0] room;
    logic        v0, v1, a0, a1;

    always_comb begin
        n_req   = {1'b0, fl.alloc0_req_i} + {1'b0, fl.alloc1_req_i};
        grant   = count_q >= (PW+1)'(n_req);
        n_grant = grant ? n_req : 2'd0;
        base    = count_q - (PW+1)'(n_grant);
        room    = MAX_CNT - base;
        // preg 0 backs x0 and must never re-enter the pool
        v0 = fl.release0_en_i && (fl.release0_preg_i != '0);
        v1 = fl.release1_en_i && (fl.release1_preg_i != '0);
        a0 = v0 && (room != '0);
        a1 = v1 && (room > (PW+1)'(a0));

        fifo_d = fifo_q;
        if (a0) fifo_d[tail_q] = fl.release0_preg_i;
        if (a1) fifo_d[tail_q + PW'(a0)] = fl.release1_preg_i;

        head_d  = head_q + PW'(n_grant);
        tail_d  = tail_q + PW'(a0) + PW'(a1);
        count_d = base + (PW+1)'(a0) + (PW+1)'(a1);
        ovf_d   = ovf_q | (v0 & ~a0) | (v1 & ~a1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_P_REGS; i++) begin
                fifo_q[i] <= (i < NUM_P_REGS - NUM_A_REGS)
                           ? PW'(NUM_A_REGS + i) : '0;
            end
            head_q  <= '0;
            tail_q  <= PW'(NUM_P_REGS - NUM_A_REGS);
            count_q <= RST_CNT;
            ovf_q   <= 1'b0;
        end else begin
            fifo_q  <= fifo_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // a lone slot-1 request is packed onto the head entry
    always_comb begin
        fl.alloc0_preg_o  = fifo_q[head_q];
        fl.alloc1_preg_o  = fl.alloc0_req_i ? fifo_q[head_q + PW'(1)]
                                            : fifo_q[head_q];
        fl.alloc_grant_o  = grant;
        fl.free_count_o   = count_q;
        fl.empty_o        = (count_q == '0);
        fl.overflow_err_o = ovf_q;
    end
endmodule
